seg_scan_driver: RTL and testbench

- Parametrised multiplexed seven-segment display driver. Generalises the fixed 8-digit hex decoder/scanner pair to DIGITS digits.
- Adds a programmable scan rate, per-digit decimal points and PWM brightness.
- Adds tear-free double-buffered data loading and a frame-done strobe.
- Sits between the CPU output register and the board segment/anode pins.

---
 rtl/seg_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: DIGITS-digit multiplexed 7-seg scanner with PWM dimming and double-buffered load; SEG_LZ_SUPPRESS_EN adds leading-zero blanking.
// Latency: one registered cycle from scan state to pins; no backpressure, load is accepted on any cycle.
module seg_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int CLK_DIV  = 100000,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     disp_valid,
  input  logic [DIGITS-1:0]     disp_dp,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            seg_data,
  output logic [DIGITS-1:0]     seg_an,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [4*DIGITS-1:0] pend_data, shad_data;
  logic [DIGITS-1:0]   pend_valid, pend_dp, shad_valid, shad_dp;
  logic                pend_flag;
  logic                wrap_d;

  logic       slot_end, wrap;
  logic [3:0] cur_nib;
  logic [6:0] cur_pat;
  logic       cur_valid, cur_dp, pwm_lit, cur_sup, cur_show;

  assign slot_end = (presc == PRESC_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h01;
      4'h1: pat = 7'h4F;
      4'h2: pat = 7'h12;
      4'h3: pat = 7'h06;
      4'h4: pat = 7'h4C;
      4'h5: pat = 7'h24;
      4'h6: pat = 7'h20;
      4'h7: pat = 7'h0F;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h04;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h60;
      4'hC: pat = 7'h31;
      4'hD: pat = 7'h42;
      4'hE: pat = 7'h30;
      default: pat = 7'h38;
    endcase
    return pat;
  endfunction

`ifdef SEG_LZ_SUPPRESS_EN
  logic [DIGITS-1:0] lz_mask, lz_next;
  logic              lz_run;

  // Mask is derived from the buffer about to become shadow, so it switches on the same edge.
  always_comb begin
    lz_next = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lz_run && pend_valid[i] && (pend_data[4*i +: 4] == 4'h0)) begin
        lz_next[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lz_mask <= '0;
    end else if (wrap && pend_flag) begin
      lz_mask <= lz_next;
    end
  end

  assign cur_sup = lz_mask[idx];
`else
  assign cur_sup = 1'b0;
`endif

  always_comb begin
    cur_nib   = shad_data[{idx, 2'b00} +: 4];
    cur_pat   = hex_seg(cur_nib);
    cur_valid = shad_valid[idx];
    cur_dp    = shad_dp[idx];
    pwm_lit   = (brightness == '1) || (pwm_cnt < brightness);
    cur_show  = cur_valid && pwm_lit && !cur_sup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      pend_data  <= '0;
      pend_valid <= '0;
      pend_dp    <= '0;
      shad_data  <= '0;
      shad_valid <= '0;
      shad_dp    <= '0;
      pend_flag  <= 1'b0;
      wrap_d     <= 1'b0;
      frame_done <= 1'b0;
      seg_an     <= '1;
      seg_data   <= 8'hFF;
    end else begin
      presc   <= slot_end ? '0 : presc + 1'b1;
      pwm_cnt <= slot_end ? '0 : pwm_cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      // Wrap moves the old pending value; a coincident load lands in pending for the next frame.
      if (wrap && pend_flag) begin
        shad_data  <= pend_data;
        shad_valid <= pend_valid;
        shad_dp    <= pend_dp;
      end
      if (load) begin
        pend_data  <= disp_data;
        pend_valid <= disp_valid;
        pend_dp    <= disp_dp;
        pend_flag  <= 1'b1;
      end else if (wrap) begin
        pend_flag  <= 1'b0;
      end

      wrap_d     <= wrap;
      frame_done <= wrap_d;
      seg_an     <= cur_show ? ~(DIGITS'(1) << idx) : '1;
      seg_data   <= cur_show ? {cur_pat, ~cur_dp} : 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: test-plan vector table, hand sequences and random traffic against a cycle-time reference model.
module tb_seg_scan_driver;
  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 4;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = DIGITS * CLK_DIV;
`ifdef SEG_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [4*DIGITS-1:0] disp_data = '0;
  logic [DIGITS-1:0]   disp_valid = '0;
  logic [DIGITS-1:0]   disp_dp = '0;
  logic                load = 1'b0;
  logic [BRIGHT_W-1:0] brightness = '1;
  logic [7:0]          seg_data;
  logic [DIGITS-1:0]   seg_an;
  logic                frame_done;

  seg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BRIGHT_W(BRIGHT_W)) dut (
    .clk(clk), .rst(rst), .disp_data(disp_data), .disp_valid(disp_valid),
    .disp_dp(disp_dp), .load(load), .brightness(brightness),
    .seg_data(seg_data), .seg_an(seg_an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time t counts cycles since reset release; digit/pwm follow from t.
  int                  t = 0;
  logic [4*DIGITS-1:0] m_sh_d = '0, m_pd_d = '0;
  logic [DIGITS-1:0]   m_sh_v = '0, m_sh_dp = '0, m_pd_v = '0, m_pd_dp = '0;
  bit                  m_pd_f = 1'b0;
  logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_expect(output logic [DIGITS-1:0] ea, output logic [7:0] es,
                                       output logic ef);
    int d, p;
    bit show, all0;
    logic [3:0] nib;
    ea = '1; es = 8'hFF; ef = 1'b0;
    if (rst) return;
    d    = (t / CLK_DIV) % DIGITS;
    p    = (t % CLK_DIV) % (1 << BRIGHT_W);
    nib  = m_sh_d[4*d +: 4];
    show = m_sh_v[d] && ((brightness == '1) || (p < int'(brightness)));
    all0 = (d != 0);
    for (int j = d; j < DIGITS; j++)
      if (!(m_sh_v[j] && (m_sh_d[4*j +: 4] == 4'h0))) all0 = 1'b0;
    if (LZ && all0) show = 1'b0;
    ef = (t > 0) && (t % FRAME == 0);
    if (show) begin
      ea = ~(DIGITS'(1) << d);
      es = {hex_tab[nib][7:1], ~m_sh_dp[d]};
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      t = 0; m_pd_f = 1'b0;
      m_sh_d = '0; m_sh_v = '0; m_sh_dp = '0;
      m_pd_d = '0; m_pd_v = '0; m_pd_dp = '0;
    end else begin
      if ((t % FRAME == FRAME - 1) && m_pd_f) begin
        m_sh_d = m_pd_d; m_sh_v = m_pd_v; m_sh_dp = m_pd_dp; m_pd_f = 1'b0;
      end
      if (load) begin
        m_pd_d = disp_data; m_pd_v = disp_valid; m_pd_dp = disp_dp; m_pd_f = 1'b1;
      end
      t++;
    end
  endfunction

  task automatic cyc();
    logic [DIGITS-1:0] ea;
    logic [7:0] es;
    logic ef;
    model_expect(ea, es, ef);
    model_step();
    @(posedge clk);
    #1;
    check("seg_an", 32'(seg_an), 32'(ea));
    check("seg_data", 32'(seg_data), 32'(es));
    check("frame_done", 32'(frame_done), 32'(ef));
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] v,
                         input logic [DIGITS-1:0] dp);
    disp_data = d; disp_valid = v; disp_dp = dp; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      cyc();
      seen = frame_done;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  valid;
    logic [3:0]  dp;
    int          slot;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;
  vec_t tab [12];

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, first, last;
    logic [DIGITS-1:0] lit_any;
    logic [15:0] mask;
    bit seen, saw0d, early;
    int n49;

    tab[0]  = '{16'h12AF, 4'hF, 4'b0000, 0, 4'b1110, 8'h71};
    tab[1]  = '{16'h12AF, 4'hF, 4'b0000, 1, 4'b1101, 8'h11};
    tab[2]  = '{16'h12AF, 4'hF, 4'b0000, 2, 4'b1011, 8'h25};
    tab[3]  = '{16'h12AF, 4'hF, 4'b0000, 3, 4'b0111, 8'h9F};
    tab[4]  = '{16'h12AF, 4'b0101, 4'b0001, 0, 4'b1110, 8'h70};
    tab[5]  = '{16'h12AF, 4'b0101, 4'b0001, 1, 4'b1111, 8'hFF};
    tab[6]  = '{16'h12AF, 4'b0101, 4'b0001, 2, 4'b1011, 8'h25};
    tab[7]  = '{16'h12AF, 4'b0101, 4'b0001, 3, 4'b1111, 8'hFF};
    tab[8]  = '{16'h0070, 4'hF, 4'b0000, 0, 4'b1110, 8'h03};
    tab[9]  = '{16'h0070, 4'hF, 4'b0000, 1, 4'b1101, 8'h1F};
    tab[10] = '{16'h0070, 4'hF, 4'b0000, 2, LZ ? 4'b1111 : 4'b1011, LZ ? 8'hFF : 8'h03};
    tab[11] = '{16'h0070, 4'hF, 4'b0000, 3, LZ ? 4'b1111 : 4'b0111, LZ ? 8'hFF : 8'h03};

    // Reset and idle scanning
    repeat (3) cyc();
    check("rst_an", 32'(seg_an), 32'hF);
    check("rst_seg", 32'(seg_data), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    cnt = 0; first = -1; last = -1; lit_any = '0;
    for (int i = 0; i < 3 * FRAME + 1; i++) begin
      cyc();
      lit_any |= ~seg_an;
      if (frame_done) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("idle_blank", 32'(lit_any), 32'd0);
    check("idle_fd_count", 32'(cnt), 32'd3);
    check("idle_fd_first", 32'(first), 32'd16);
    check("idle_fd_span", 32'(last - first), 32'd32);

    // Vector table: load, wait for the frame it lands in, then step slot by slot
    brightness = '1;
    for (int k = 0; k < 12; k++) begin
      if (tab[k].slot == 0) begin
        do_load(tab[k].data, tab[k].valid, tab[k].dp);
        wait_frame("tab_frame");
      end else begin
        repeat (CLK_DIV) cyc();
      end
      check($sformatf("tab%0d_an", k), 32'(seg_an), 32'(tab[k].an));
      check($sformatf("tab%0d_seg", k), 32'(seg_data), 32'(tab[k].seg));
    end

    // PWM duty
    brightness = 2'b01;
    do_load(16'h12AF, 4'hF, 4'h0);
    wait_frame("pwm_frame");
    mask = '0;
    mask[0] = (seg_an != '1);
    for (int i = 1; i < FRAME; i++) begin
      cyc();
      mask[i] = (seg_an != '1);
    end
    check("bright1_mask", 32'(mask), 32'h1111);
    brightness = 2'b00;
    lit_any = '0;
    repeat (FRAME) begin
      cyc();
      lit_any |= ~seg_an;
    end
    check("bright0_dark", 32'(lit_any), 32'd0);

    // Two loads in one frame: last wins, old frame untouched
    brightness = '1;
    wait_frame("dbl_frame");
    repeat (5) cyc();
    do_load(16'h3333, 4'hF, 4'h0);
    repeat (3) cyc();
    do_load(16'h5555, 4'hF, 4'h0);
    seen = 1'b0; saw0d = 1'b0; early = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      cyc();
      seen = frame_done;
      if (seg_data == 8'h0D) saw0d = 1'b1;
      if (!seen && seg_data == 8'h49) early = 1'b1;
    end
    check("dbl_wrap_seen", 32'(seen), 32'd1);
    n49 = (seg_data == 8'h49) ? 1 : 0;
    for (int i = 1; i < FRAME; i++) begin
      cyc();
      if (seg_data == 8'h49) n49++;
      if (seg_data == 8'h0D) saw0d = 1'b1;
    end
    check("dbl_new_frame", 32'(n49), 32'(FRAME));
    check("dbl_never_3333", 32'(saw0d), 32'd0);
    check("dbl_no_early", 32'(early), 32'd0);

    // Reset during slot 2
    wait_frame("rst_frame");
    repeat (2 * CLK_DIV) cyc();
    rst = 1'b1;
    cyc();
    check("midrst_an", 32'(seg_an), 32'hF);
    check("midrst_seg", 32'(seg_data), 32'hFF);
    cyc();
    rst = 1'b0;
    lit_any = '0;
    repeat (40) begin
      cyc();
      lit_any |= ~seg_an;
    end
    check("postrst_blank", 32'(lit_any), 32'd0);
    do_load(16'h5555, 4'hF, 4'h0);
    wait_frame("postrst_frame");
    check("postrst_an", 32'(seg_an), 32'hE);
    check("postrst_seg", 32'(seg_data), 32'h49);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < DIGITS; j++)
        disp_data[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      disp_valid = ($urandom_range(0, 3) == 0) ? DIGITS'($urandom) : '1;
      disp_dp    = DIGITS'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = BRIGHT_W'($urandom);
      cyc();
    end
    rst = 1'b0; load = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
